// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } tgt_state_t;

  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;
  localparam int   I2C_ADDR_W = 7;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with edge and START/STOP strobes.
// Optional glitch filter on each line when I2C_GLITCH_FILTER_EN is defined.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
`ifdef I2C_GLITCH_FILTER_EN
  , parameter int FILT_LEN  = 4
`endif
) (
  input  logic clk,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] raw_in;
  logic [1:0] line_s;
  logic [1:0] line_prev;
  logic [1:0] rise;
  logic [1:0] fall;

  assign raw_in = {sda_i, scl_i};

  // Line registers carry no reset: a mid-transfer reset must not fabricate bus edges.
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[gi]};
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILT_LEN + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;

    always_ff @(posedge clk) begin
      if (sync_q[SYNC_STAGES-1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        filt_q <= sync_q[SYNC_STAGES-1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign line_s[gi] = filt_q;
`else
    assign line_s[gi] = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
      prev_q <= line_s[gi];
    end

    assign line_prev[gi] = prev_q;
    assign rise[gi]      = line_s[gi] & ~prev_q;
    assign fall[gi]      = ~line_s[gi] & prev_q;
  end

  assign sda_o      = line_s[1];
  assign scl_rise_o = rise[0];
  assign scl_fall_o = fall[0];
  assign start_o    = fall[1] & line_s[0] & line_prev[0];
  assign stop_o     = rise[1] & line_s[0] & line_prev[0];

endmodule

// File: rtl/i2c_target.sv
// Oversampled I2C target: address match, multi-byte write receive, read serve.
// Build with I2C_GLITCH_FILTER_EN defined to add the per-line glitch filter.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int                    SYNC_STAGES = 2
`ifdef I2C_GLITCH_FILTER_EN
  , parameter int                  FILT_LEN    = 4
`endif
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       busy
);

  logic sda_s, scl_rise, scl_fall, start_s, stop_s;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef I2C_GLITCH_FILTER_EN
    , .FILT_LEN (FILT_LEN)
`endif
  ) u_bus_sync (
    .clk       (clk),
    .scl_i     (scl),
    .sda_i     (sda),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_s),
    .stop_o    (stop_s)
  );

  tgt_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;
  logic       oe_q, oe_d;
  logic       done_q, done_d;    // byte complete (ADDR/WR) or master ACKed (RD_ACK)
  logic       rw_q, rw_d;
  logic       samp_q, fall_q;    // SCL edge strobes delayed one clk

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd7;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      rw_q       <= 1'b0;
      samp_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      rw_q       <= rw_d;
      samp_q     <= scl_rise;
      fall_q     <= scl_fall;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    busy_d     = busy_q;
    oe_d       = oe_q;
    done_d     = done_q;
    rw_d       = rw_q;

    // STOP outranks START, which outranks any bit sample in the same clk.
    if (stop_s) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      done_d  = 1'b0;
    end else if (start_s) begin
      state_d = ADDR;
      cnt_d   = 3'd7;
      oe_d    = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (samp_q) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) done_d = 1'b1;
            else               cnt_d  = cnt_q - 3'd1;
          end else if (fall_q && done_q) begin
            done_d = 1'b0;
            if (shift_q[7:1] == TARGET_ADDR) begin
              state_d = ADDR_ACK;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
            end else begin
              state_d = IGNORE;
              oe_d    = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (fall_q) begin
            cnt_d = 3'd7;
            if (rw_q) begin
              shift_d   = tx_data;
              tx_load_d = 1'b1;
              state_d   = RD_DATA;
              oe_d      = ~tx_data[7];
            end else begin
              state_d = WR_DATA;
              oe_d    = 1'b0;
            end
          end
        end
        WR_DATA: begin
          if (samp_q) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end else if (fall_q && done_q) begin
            done_d  = 1'b0;
            state_d = WR_ACK;
            oe_d    = 1'b1;
          end
        end
        WR_ACK: begin
          if (fall_q) begin
            state_d = WR_DATA;
            oe_d    = 1'b0;
            cnt_d   = 3'd7;
          end
        end
        RD_DATA: begin
          if (fall_q) begin
            if (cnt_q == 3'd0) begin
              state_d = RD_ACK;
              oe_d    = 1'b0;
              done_d  = 1'b0;
            end else begin
              cnt_d = cnt_q - 3'd1;
              oe_d  = ~shift_q[cnt_q - 3'd1];
            end
          end
        end
        RD_ACK: begin
          if (samp_q) begin
            if (sda_s == I2C_ACK) done_d  = 1'b1;
            else                  state_d = IGNORE;
          end else if (fall_q && done_q) begin
            done_d    = 1'b0;
            shift_d   = tx_data;
            tx_load_d = 1'b1;
            state_d   = RD_DATA;
            cnt_d     = 3'd7;
            oe_d      = ~tx_data[7];
          end
        end
        IDLE, IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  assign sda      = oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged 400 kHz master, pull-up on SDA, 50 MHz clk.
module tb_i2c_target;
  import i2c_pkg::*;

  logic       clk      = 1'b0;
  logic       arst     = 1'b1;
  logic       scl      = 1'b1;
  logic       m_sda_oe = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  wire        sda_bus;
  wire  [7:0] rx_data;
  wire        rx_valid;
  wire        tx_load;
  wire        busy;

  pullup (sda_bus);
  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;

  i2c_target dut (
    .clk     (clk),
    .arst    (arst),
    .scl     (scl),
    .sda     (sda_bus),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_load (tx_load),
    .busy    (busy)
  );

  always #10ns clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int busy_rises = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] rd_exp_q[$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s obs=0x%0h", tag, obs);
    end
  endtask

  // Scoreboard side: every rx_valid pops one expected write byte.
  initial begin
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rx_cnt++;
        if (rx_exp_q.size() == 0) check("rx_unexpected", 1, 0);
        else                      check("rx_data", rx_data, rx_exp_q.pop_front());
      end
      if (tx_load) tx_cnt++;
      if (busy && !busy_prev) busy_rises++;
      busy_prev = busy;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic i2c_start();
    m_sda_oe = 1'b0; scl = 1'b1;
    #625ns; m_sda_oe = 1'b1;
    #625ns; scl = 1'b0;
  endtask

  task automatic i2c_rep_start();
    #625ns; m_sda_oe = 1'b0;
    #625ns; scl = 1'b1;
    #625ns; m_sda_oe = 1'b1;
    #625ns; scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #625ns; m_sda_oe = 1'b1;
    #625ns; scl = 1'b1;
    #625ns; m_sda_oe = 1'b0;
    #625ns;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    #625ns; m_sda_oe = ~b;
    #625ns; scl = 1'b1;
    if (glitch) begin
      #300ns;
      @(posedge clk); #1ns scl = 1'b0;
      #40ns scl = 1'b1;
      #900ns;
    end else begin
      #1250ns;
    end
    scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    #625ns; m_sda_oe = 1'b0;
    #625ns; scl = 1'b1;
    #625ns; b = sda_bus;
    #625ns; scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
    recv_bit(ack);
  endtask

  task automatic recv_bits(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1ns arst = 1'b1;
    @(posedge clk); #1ns arst = 1'b0;
  endtask

  initial begin
    logic ack;
    logic b;
    logic [7:0] d;
    int rx0, tx0, br0;

    repeat (10) @(posedge clk);
    #1ns arst = 1'b0;
    @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_load", tx_load, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda_bus, 1);
    check("rst_state", int'(dut.state_q), int'(IDLE));

    // 1: write 0xA5 to 0x50
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'hA0, -1, ack);
    check("t1_addr_ack", ack, I2C_ACK);
    check("t1_busy", busy, 1);
    rx_exp_q.push_back(8'hA5);
    send_byte(8'hA5, -1, ack);
    check("t1_data_ack", ack, I2C_ACK);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("t1_busy_end", busy, 0);
    check("t1_rx_pulses", rx_cnt - rx0, 1);

    // 2: read 0x3C from 0x50, master NACKs
    tx0 = tx_cnt;
    tx_data = 8'h3C;
    rd_exp_q.push_back(8'h3C);
    i2c_start();
    send_byte(8'hA1, -1, ack);
    check("t2_addr_ack", ack, I2C_ACK);
    recv_bits(d);
    check("t2_rd_byte", d, rd_exp_q.pop_front());
    send_bit(I2C_NACK, 1'b0);
    repeat (5) @(negedge clk);
    check("t2_state_ignore", int'(dut.state_q), int'(IGNORE));
    check("t2_tx_loads", tx_cnt - tx0, 1);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("t2_state_idle", int'(dut.state_q), int'(IDLE));
    check("t2_busy_end", busy, 0);

    // 3: write to 0x51 is not acknowledged
    rx0 = rx_cnt;
    br0 = busy_rises;
    i2c_start();
    send_byte(8'hA2, -1, ack);
    check("t3_addr_nack", ack, I2C_NACK);
    send_byte(8'h11, -1, ack);
    check("t3_data_nack", ack, I2C_NACK);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("t3_rx_pulses", rx_cnt - rx0, 0);
    check("t3_busy_rises", busy_rises - br0, 0);

    // 4: write 0xFF, repeated START, two-byte read
    br0 = busy_rises;
    tx0 = tx_cnt;
    i2c_start();
    send_byte(8'hA0, -1, ack);
    check("t4_addr_w_ack", ack, I2C_ACK);
    rx_exp_q.push_back(8'hFF);
    send_byte(8'hFF, -1, ack);
    check("t4_data_ack", ack, I2C_ACK);
    i2c_rep_start();
    check("t4_busy_rpt", busy, 1);
    tx_data = 8'h81;
    rd_exp_q.push_back(8'h81);
    rd_exp_q.push_back(8'h96);
    send_byte(8'hA1, -1, ack);
    check("t4_addr_r_ack", ack, I2C_ACK);
    recv_bits(d);
    tx_data = 8'h96;
    check("t4_rd_byte0", d, rd_exp_q.pop_front());
    send_bit(I2C_ACK, 1'b0);
    recv_bits(d);
    check("t4_rd_byte1", d, rd_exp_q.pop_front());
    send_bit(I2C_NACK, 1'b0);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("t4_rx_data", rx_data, 8'hFF);
    check("t4_tx_loads", tx_cnt - tx0, 2);
    check("t4_busy_rises", busy_rises - br0, 1);

    // 5a: reset while the target drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5, 1'b0);
    #625ns; m_sda_oe = 1'b0;
    #625ns; scl = 1'b1;
    #300ns;
    check("t5_ack_driven", sda_bus, 0);
    pulse_reset();
    @(negedge clk);
    check("t5_ack_released", sda_bus, 1);
    check("t5_busy_cleared", busy, 0);
    #600ns; scl = 1'b0;
    i2c_stop();

    // 5b: reset during the 4th data bit of a write
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'hA0, -1, ack);
    check("t5_addr_ack", ack, I2C_ACK);
    d = 8'hB7;
    for (int i = 7; i >= 5; i--) send_bit(d[i], 1'b0);
    #625ns; m_sda_oe = ~d[4];
    #625ns; scl = 1'b1;
    #300ns;
    pulse_reset();
    @(negedge clk);
    check("t5_sda_released", sda_bus, 1);
    check("t5_state_idle", int'(dut.state_q), int'(IDLE));
    #900ns; scl = 1'b0;
    for (int i = 3; i >= 0; i--) send_bit(d[i], 1'b0);
    recv_bit(b);
    check("t5_data_nack", b, I2C_NACK);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("t5_rx_pulses", rx_cnt - rx0, 0);
    i2c_start();
    send_byte(8'hA0, -1, ack);
    check("t5_next_addr_ack", ack, I2C_ACK);
    rx_exp_q.push_back(8'h5A);
    send_byte(8'h5A, -1, ack);
    check("t5_next_data_ack", ack, I2C_ACK);
    i2c_stop();
    repeat (10) @(negedge clk);

    // 6: 2-clk SCL glitch during bit 3 of 0xA5
    i2c_start();
    send_byte(8'hA0, -1, ack);
    check("t6_addr_ack", ack, I2C_ACK);
`ifdef I2C_GLITCH_FILTER_EN
    rx_exp_q.push_back(8'hA5);
    send_byte(8'hA5, 3, ack);
    check("t6_data_ack", ack, I2C_ACK);
`else
    rx_exp_q.push_back(8'hA2);
    send_byte(8'hA5, 3, ack);
    check("t6_data_ack", ack, I2C_NACK);
`endif
    i2c_stop();
    repeat (10) @(negedge clk);

    check("end_rx_pending", rx_exp_q.size(), 0);
    check("end_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
